bru_pc_sequencer: RTL and testbench

Sequences the program counter around the branch-resolution unit. It accepts control-transfer instructions from decode, evaluates the branch condition from the ALU compare flags using the team's BRUOP encoding, computes the target, and drives the instruction-memory fetch handshake. On a taken branch or jump it flushes younger instructions for a fixed number of cycles, then restarts fetch at the target. A misaligned target halts fetch with a sticky exception flag.

---
 rtl/bru_pc_sequencer.sv | 138 +++++++++++++
 tb/tb_bru_pc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bru_pc_sequencer.sv
// PC sequencer around the branch-resolution unit: redirect after FLUSH_CYCLES bubbles, HALT on misaligned target.
// Moore ready/req/flush; pc, link and counters registered. Optional statistics counters under `BRU_STATS_EN.
module bru_pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [3:0]  BRUOP,
   input  logic        aluEQ,
   input  logic        aluLT,
   input  logic        aluLTU,
   input  logic [31:0] pc_ex,
   input  logic [31:0] rs1,
   input  logic [31:0] imm,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic [31:0] pc,
   output logic        flush,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        misalign_exc,
   output logic [31:0] br_total,
   output logic [31:0] br_taken
);

   localparam logic [1:0] FETCH    = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] HALT     = 2'd2;

   localparam logic [3:0] OP_EQ   = 4'd0;
   localparam logic [3:0] OP_NE   = 4'd1;
   localparam logic [3:0] OP_LT   = 4'd2;
   localparam logic [3:0] OP_GE   = 4'd3;
   localparam logic [3:0] OP_JAL  = 4'd4;
   localparam logic [3:0] OP_JALR = 4'd5;
   localparam logic [3:0] OP_LTU  = 4'd6;
   localparam logic [3:0] OP_GEU  = 4'd7;
   localparam logic [3:0] OP_OFF  = 4'd8;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   logic [1:0]  state;
   logic [3:0]  flush_cnt;
   logic        accept;
   logic        taken;
   logic        is_link;
   logic [31:0] target;

   assign br_ready  = (state == FETCH);
   assign imem_req  = (state == FETCH);
   assign flush     = (state != FETCH);
   assign imem_addr = pc;
   assign accept    = br_valid & br_ready;
   assign is_link   = (BRUOP == OP_JAL) || (BRUOP == OP_JALR);

   always_comb begin
      taken = 1'b0;
      case (BRUOP)
         OP_EQ:   taken = aluEQ;
         OP_NE:   taken = ~aluEQ;
         OP_LT:   taken = aluLT;
         OP_GE:   taken = ~aluLT;
         OP_LTU:  taken = aluLTU;
         OP_GEU:  taken = ~aluLTU;
         OP_JAL:  taken = 1'b1;
         OP_JALR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      if (BRUOP == OP_JALR) target = (rs1 + imm) & ~32'h1;
      else                  target = pc_ex + imm;
   end

   // A taken branch outranks a same-cycle fetch ack; the acked fetch dies in the flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         flush_cnt    <= 4'd0;
         misalign_exc <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (accept && taken) begin
                  if (target[1]) begin
                     state        <= HALT;
                     misalign_exc <= 1'b1;
                  end else begin
                     state     <= REDIRECT;
                     pc        <= target;
                     flush_cnt <= FLUSH_LOAD;
                  end
               end else if (imem_ack) begin
                  pc <= pc + 32'd4;
               end
            end
            REDIRECT: begin
               if (flush_cnt <= 4'd1) state <= FETCH;
               else                   flush_cnt <= flush_cnt - 4'd1;
            end
            HALT:    state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_we   <= 1'b0;
         link_data <= 32'h0;
      end else begin
         link_we <= accept & is_link;
         if (accept && is_link) link_data <= pc_ex + 32'd4;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_total <= 32'h0;
         br_taken <= 32'h0;
      end else begin
         if (accept && (BRUOP != OP_OFF)) br_total <= br_total + 32'd1;
         if (accept && taken)             br_taken <= br_taken + 32'd1;
      end
   end
`else
   assign br_total = 32'h0;
   assign br_taken = 32'h0;
`endif

endmodule

// File: tb/tb_bru_pc_sequencer.sv
// Randomized + directed bench for bru_pc_sequencer against a cycle-level behavioural model.
module tb_bru_pc_sequencer;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int          FC  = 2;
`ifdef BRU_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_valid = 1'b0;
   logic        br_ready;
   logic [3:0]  BRUOP = 4'd8;
   logic        aluEQ = 1'b0, aluLT = 1'b0, aluLTU = 1'b0;
   logic [31:0] pc_ex = 32'h0, rs1 = 32'h0, imm = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] pc;
   logic        flush;
   logic        link_we;
   logic [31:0] link_data;
   logic        misalign_exc;
   logic [31:0] br_total, br_taken;

   bru_pc_sequencer #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready), .BRUOP(BRUOP),
      .aluEQ(aluEQ), .aluLT(aluLT), .aluLTU(aluLTU), .pc_ex(pc_ex), .rs1(rs1), .imm(imm),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .pc(pc), .flush(flush),
      .link_we(link_we), .link_data(link_data), .misalign_exc(misalign_exc),
      .br_total(br_total), .br_taken(br_taken)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: fetch PC, bubbles still owed after a redirect, halted flag, sticky exception.
   logic [31:0] m_pc, m_ldata, m_total, m_taken;
   logic        m_lwe, m_halt, m_exc;
   int          m_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic rule_taken(input logic [3:0] op, input logic eq, input logic lt, input logic ltu);
      case (op)
         4'd0: return eq;
         4'd1: return !eq;
         4'd2: return lt;
         4'd3: return !lt;
         4'd4, 4'd5: return 1'b1;
         4'd6: return ltu;
         4'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic model_fetching();
      return !m_halt && (m_left == 0);
   endfunction

   task automatic model_reset();
      m_pc = RPC; m_ldata = 32'h0; m_total = 32'h0; m_taken = 32'h0;
      m_lwe = 1'b0; m_halt = 1'b0; m_exc = 1'b0; m_left = 0;
   endtask

   task automatic check_all();
      check("br_ready",  br_ready,     model_fetching());
      check("imem_req",  imem_req,     model_fetching());
      check("flush",     flush,        !model_fetching());
      check("pc",        pc,           m_pc);
      check("imem_addr", imem_addr,    m_pc);
      check("link_we",   link_we,      m_lwe);
      check("link_data", link_data,    m_ldata);
      check("misalign",  misalign_exc, m_exc);
      check("br_total",  br_total,     m_total);
      check("br_taken",  br_taken,     m_taken);
   endtask

   // Called at a falling edge: drive, advance model, clock, then check at next falling edge.
   task automatic step(input logic v, input logic [3:0] op, input logic eq, input logic lt,
                       input logic ltu, input logic [31:0] pcx, input logic [31:0] r1,
                       input logic [31:0] im, input logic ack);
      logic acc, tk;
      logic [31:0] tgt;
      br_valid = v; BRUOP = op; aluEQ = eq; aluLT = lt; aluLTU = ltu;
      pc_ex = pcx; rs1 = r1; imm = im; imem_ack = ack;
      acc = v && model_fetching();
      tk  = rule_taken(op, eq, lt, ltu);
      tgt = (op == 4'd5) ? ((r1 + im) & 32'hFFFF_FFFE) : (pcx + im);
      m_lwe = acc && (op == 4'd4 || op == 4'd5);
      if (m_lwe) m_ldata = pcx + 32'd4;
      if (STATS && acc && op != 4'd8) m_total = m_total + 32'd1;
      if (STATS && acc && tk)         m_taken = m_taken + 32'd1;
      if (m_halt) begin
      end else if (m_left > 0) begin
         m_left = m_left - 1;
      end else if (acc && tk) begin
         if (tgt[1]) begin m_halt = 1'b1; m_exc = 1'b1; end
         else begin m_pc = tgt; m_left = FC; end
      end else if (ack) begin
         m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input logic ack);
      step(1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ack);
   endtask

   // Asserted away from any clock edge to exercise the asynchronous path.
   task automatic do_reset();
      rst = 1'b1; br_valid = 1'b0; imem_ack = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_flush", flush, 1'b0);
      check("rst_req", imem_req, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Sequential fetch
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", imem_addr, 32'(4 * i));
         idle(1'b1);
      end
      check("seq_flush", flush, 1'b0);

      // BEQ taken, then async reset mid-redirect
      step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h20, 1'b0);
      check("beq_flush1", flush, 1'b1);
      check("beq_req1", imem_req, 1'b0);
      idle(1'b1);
      check("beq_flush2", flush, 1'b1);
      idle(1'b0);
      check("beq_flush3", flush, 1'b0);
      check("beq_addr", imem_addr, 32'h120);
      step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h20, 1'b0);
      do_reset();

      // BGEU taken, then BLTU not taken with ack
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h40, 1'b0);
      idle(1'b0); idle(1'b0);
      check("bgeu_addr", imem_addr, 32'h240);
      step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h40, 1'b1);
      check("bltu_pc", pc, 32'h244);
      check("bltu_flush", flush, 1'b0);

      // JALR misaligned -> HALT
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 32'h300, 32'h203, 32'h0, 1'b1);
      check("jalr_exc", misalign_exc, 1'b1);
      check("jalr_lwe", link_we, 1'b1);
      check("jalr_ldata", link_data, 32'h304);
      check("jalr_pc", pc, 32'h244);
      idle(1'b1); idle(1'b1);
      check("halt_sticky", misalign_exc, 1'b1);
      check("halt_ready", br_ready, 1'b0);
      do_reset();

      // JAL wrapping target, same cycle as ack
      step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h20, 1'b1);
      check("jal_pc", pc, 32'h10);
      check("jal_ldata", link_data, 32'hFFFF_FFF4);
      do_reset();

      // Statistics: 3 taken, 2 not taken, 1 OFF
      step(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0); idle(1'b0); idle(1'b0);
      step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20, 1'b0); idle(1'b0); idle(1'b0);
      step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h30, 1'b0); idle(1'b0); idle(1'b0);
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h30, 1'b1);
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h30, 1'b1);
      step(1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h30, 1'b1);
      check("stats_total", br_total, STATS ? 32'd5 : 32'd0);
      check("stats_taken", br_taken, STATS ? 32'd3 : 32'd0);

      // Randomized episodes
      for (int ep = 0; ep < 20; ep++) begin
         do_reset();
         for (int c = 0; c < 80; c++) begin
            logic [31:0] pcx, r1, im;
            pcx = $urandom & 32'hFFFF_FFFC;
            im  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
            r1  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1))
                  | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
            step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), 1'($urandom), pcx, r1, im, 1'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
